// File: rtl/pedal_chain_sequencer.sv
// pedal_chain_sequencer
// Carries one audio sample at a time through NUM_SLOTS effect slots in series.
// Slot 0 runs first. Each slot has a start/done handshake and a per-sample
// latched bypass bit. Each sample produces one registered result.
// Optional feature: define PEDAL_TIMEOUT_EN to abandon a slot that has not
// answered within TIMEOUT cycles. When the macro is undefined, the sequencer
// waits indefinitely and timeout_err stays 0.
module pedal_chain_sequencer #(
  parameter int WIDTH     = 16,
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           sample_in,
  input  logic                       sample_valid,
  input  logic [NUM_SLOTS-1:0]       bypass,
  output logic [WIDTH-1:0]           slot_data,
  output logic [NUM_SLOTS-1:0]       slot_start,
  input  logic [NUM_SLOTS*WIDTH-1:0] slot_out,
  input  logic [NUM_SLOTS-1:0]       slot_done,
  output logic [WIDTH-1:0]           sample_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout_err
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    EMIT = 2'd2
  } state_t;

  if ((NUM_SLOTS < 1) || (NUM_SLOTS > 8) || (TIMEOUT < 1)) begin : g_param_check
    $error("pedal_chain_sequencer: NUM_SLOTS must be 1..8 and TIMEOUT >= 1");
  end

  state_t               state_reg;
  logic [IW-1:0]        idx_reg;
  logic [WIDTH-1:0]     work_reg;
  logic [NUM_SLOTS-1:0] byp_reg;
  logic [WIDTH-1:0]     sample_out_reg;
  logic                 out_valid_reg;

  // Slot results unpacked so the active one can be selected by idx.
  logic [WIDTH-1:0] slot_res [NUM_SLOTS];

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_unpack
    assign slot_res[gi] = slot_out[gi*WIDTH +: WIDTH];
  end

  logic             cur_byp;
  logic             cur_done;
  logic [WIDTH-1:0] cur_res;
  logic             last_slot;
  logic             in_slot;
  logic             active;
  logic             waiting;
  logic             expired;
  logic             advance;
  logic             take;

  assign in_slot   = (state_reg == SLOT);
  assign cur_byp   = byp_reg[idx_reg];
  assign cur_done  = slot_done[idx_reg];
  assign cur_res   = slot_res[idx_reg];
  assign last_slot = (idx_reg == IW'(NUM_SLOTS - 1));
  assign active    = in_slot && !cur_byp;
  assign waiting   = active && !cur_done;
  // A bypassed slot always leaves after one cycle. An active slot leaves on
  // done, or on expiry when the timeout feature is built in.
  assign advance   = in_slot && (cur_byp || cur_done || expired);
  assign take      = active && cur_done;

  // One-hot start to the active, non-bypassed slot. It is held until the
  // sequencer moves on.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_start
    assign slot_start[gi] = active && (idx_reg == IW'(gi));
  end

  assign slot_data   = active ? work_reg : '0;
  assign sample_out  = sample_out_reg;
  assign out_valid   = out_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign overrun     = sample_valid && (state_reg != IDLE) && !Reset;

`ifdef PEDAL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt_reg;
  logic          timeout_err_reg;

  assign expired     = waiting && (wait_cnt_reg == CW'(TIMEOUT - 1));
  assign timeout_err = timeout_err_reg;

  // Count the cycles an active slot has waited. The count restarts on every
  // slot entry. The sticky error is raised when a slot is abandoned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else if (waiting && !expired) begin
      wait_cnt_reg <= wait_cnt_reg + CW'(1);
    end else begin
      wait_cnt_reg <= '0;
      if (expired) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Sequencer: capture in IDLE, walk the slots, then present the result.
  // The result and out_valid are registered on the edge that leaves the last
  // slot, so both are visible during the EMIT cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      work_reg       <= '0;
      byp_reg        <= '0;
      sample_out_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            work_reg  <= sample_in;
            byp_reg   <= bypass;
            idx_reg   <= '0;
            state_reg <= SLOT;
          end
        end
        SLOT: begin
          if (advance) begin
            if (take) begin
              work_reg <= cur_res;
            end
            if (last_slot) begin
              sample_out_reg <= take ? cur_res : work_reg;
              out_valid_reg  <= 1'b1;
              state_reg      <= EMIT;
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end
        EMIT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
